fetch_unit: RTL
===============

# fetch_unit

Instruction fetch sequencer that feeds the opcode-driven control decoder. Owns the program counter, reads 9-bit instructions from a synchronous instruction ROM, and presents each one to the decode stage with a valid/ready handshake. It consumes the decoder's `branch` output and the ALU compare result to select the next PC. The design is non-pipelined at 3 cycles per instruction, and it halts at the end of the program.

## Interface
- `PC_W`, 10: program counter / ROM address width.
- `INSTR_W`, 9: instruction width; opcode = `instr[8:6]`.
- `PROG_LEN`, 1024: number of program words; the last valid PC is `PROG_LEN-1`.
- `LUT_IDX_W`, 4: branch target LUT index width; index = `instr[3:0]`.

Ports:
- `CLK` in 1: single clock, all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Start` in 1: begin execution at PC 0; sampled only in IDLE.
- `imem_addr` out `PC_W`: ROM address, equal to the registered PC.
- `imem_rdata` in `INSTR_W`: ROM data, valid the cycle after the address.
- `instr` out `INSTR_W`: registered current instruction.
- `opcode` out 3: `instr[8:6]`, driven to the control decoder.
- `instr_valid` out 1: `instr` is presented to decode.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `branch` in 1: decoder branch control for the presented instruction.
- `bne_taken` in 1: ALU compare says operands are not equal.
- `Halt` out 1: program finished; sticky until Reset.

## Operation
- The FSM has 5 states: IDLE, ISSUE, CAPTURE, HOLD, HALT.
- IDLE: `Start`=1 → ISSUE. Otherwise stay in IDLE.
- ISSUE: `imem_addr`=PC is presented to the ROM. Next state is CAPTURE, unconditionally.
- CAPTURE: `instr` <= `imem_rdata`. Next state is HOLD.
- HOLD: `instr_valid`=1.
  - Without a handshake (`instr_ready`=0), stay in HOLD; `instr` and PC stay stable.
  - On handshake (`instr_valid` & `instr_ready`), compute the next PC:
    - `branch` & `bne_taken` → PC <= `branch_lut[instr[3:0]]`, next state ISSUE.
    - Else, if PC == `PROG_LEN-1` → next state HALT; PC is held.
    - Else → PC <= PC+1, next state ISSUE.
- HALT: `Halt`=1 and `instr_valid`=0. `Start` is ignored. Only Reset exits this state.
- `branch` and `bne_taken` are sampled only in the handshake cycle. They are don't-care at all other times.
- A taken branch from the last PC does not halt.
- A LUT target ≥ `PROG_LEN` is a program error and is not checked. PC arithmetic is modulo 2^`PC_W`.
- `Start` asserted in any state other than IDLE has no effect.

## Timing
- Reset (sampled high at an edge) takes effect on the following edge:
  - state=IDLE, PC=0, `instr`=0, `instr_valid`=0, `Halt`=0, hence `imem_addr`=0 and `opcode`=0.
  - Reset has priority over every other event, in any state, including mid-fetch and HOLD.
- `Start` high in cycle t (IDLE) gives:
  - t+1: ISSUE with `imem_addr`=0.
  - t+2: CAPTURE.
  - t+3: HOLD with `instr_valid`=1.
- A handshake in cycle h gives ISSUE at h+1 with the new `imem_addr`. Throughput is 1 instruction per 3 cycles when `instr_ready`=1.
- `instr_valid` is purely a state decode (HOLD) and has no combinational path from `instr_ready`.
- A handshake in HOLD at PC=`PROG_LEN-1` (not taken) gives HALT, `Halt`=1, in cycle h+1.

## Structure
- The shared package `definitions` holds:
  - the `fetch_state_t` enum;
  - opcode constants `OP_SB`=0, `OP_LB`=1, `OP_ADD`=2, `OP_AND`=3, `OP_XOR`=4, `OP_CPY`=5, `OP_SL`=6, `OP_BNE`=7;
  - the `BRANCH_TARGETS` constant array (16 × `PC_W`).
- Sub-module `branch_lut`: a combinational 16-entry ROM indexed by `instr[3:0]`, with contents taken from `BRANCH_TARGETS`.

## Test plan
- Reset, then `Start` pulse, with `PROG_LEN`=3 and `instr_ready`=1, branch=0 → `imem_addr` goes 0, 1, 2 in ISSUE cycles t+1, t+4, t+7; `instr_valid` is high at t+3, t+6, t+9; `Halt`=1 from t+10.
- Backpressure: `instr_ready`=0 for 4 cycles in HOLD at PC=1 → `instr`, `opcode` and PC are unchanged and `instr_valid` stays 1. Ready=1 gives `imem_addr`=2 on the next cycle.
- Taken branch: `instr`=9'b111_00_0101, `branch`=1, `bne_taken`=1, `BRANCH_TARGETS[5]`=10'h020 → the next ISSUE has `imem_addr`=10'h020.
- Not-taken branch: same `instr`, `bne_taken`=0 at PC=7 → next `imem_addr`=8.
- Taken branch at PC=`PROG_LEN-1`, target 0 → no halt, `imem_addr`=0.
- Reset asserted in CAPTURE and again in HALT → IDLE next cycle with all outputs at reset values. `Start` is required to restart, and fetch restarts at PC 0.

Source files
------------

// File: rtl/definitions.sv
// Shared types and constants for the instruction fetch sequencer and decode stage.
package definitions;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD,
    HALT
  } fetch_state_t;

  localparam logic [2:0] OP_SB  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_CPY = 3'd5;
  localparam logic [2:0] OP_SL  = 3'd6;
  localparam logic [2:0] OP_BNE = 3'd7;

  localparam int TARGET_W    = 10;
  localparam int LUT_ENTRIES = 16;

  // Absolute branch destinations selected by the low four bits of a BNE instruction.
  localparam logic [TARGET_W-1:0] BRANCH_TARGETS [LUT_ENTRIES] = '{
    10'h000, 10'h003, 10'h007, 10'h00c,
    10'h014, 10'h020, 10'h001, 10'h01e,
    10'h008, 10'h00f, 10'h019, 10'h002,
    10'h023, 10'h026, 10'h027, 10'h00a
  };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch target ROM indexed by the low instruction bits.
module branch_lut
  import definitions::*;
#(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 4
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  assign target = PC_W'(BRANCH_TARGETS[idx]);

endmodule

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch sequencer: owns the PC, fetches from a synchronous
// ROM and hands each instruction to decode with a valid/ready handshake.
module fetch_unit
  import definitions::*;
#(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 9,
  parameter int PROG_LEN  = 1024,
  parameter int LUT_IDX_W = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               bne_taken,
  output logic               Halt
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] lut_target;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .idx    (instr[LUT_IDX_W-1:0]),
    .target (lut_target)
  );

  assign imem_addr = pc;
  assign opcode    = instr[INSTR_W-1 -: 3];

  // instr_valid and Halt are registered alongside the state so they are pure state decodes.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      Halt        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) state <= ISSUE;
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            // A taken branch wins over end-of-program, so the last word can loop back.
            if (branch && bne_taken) begin
              pc    <= lut_target;
              state <= ISSUE;
            end else if (pc == LAST_PC) begin
              Halt  <= 1'b1;
              state <= HALT;
            end else begin
              pc    <= pc + PC_W'(1);
              state <= ISSUE;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
